// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the RV32I load/store unit.
package lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'b00;
    localparam lsu_state_t ST_ACC0 = 2'b01;
    localparam lsu_state_t ST_ACC1 = 2'b10;
    localparam lsu_state_t ST_RESP = 2'b11;

    function automatic logic [3:0] size_mask(input logic [2:0] op);
        logic [3:0] m;
        case (op[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic op_legal(input logic [2:0] op, input logic is_store);
        logic ok;
        case (op)
            OP_B, OP_H, OP_W: ok = 1'b1;
            OP_BU, OP_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/mask placement and load extraction/extension.
module lsu_lane_align (
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [3:0]  smask,
    input  logic [2:0]  op,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [31:0] wlane0,
    output logic [31:0] wlane1,
    output logic [7:0]  mask,
    output logic [31:0] rdata_ext
);
    import lsu_pkg::*;

    logic [5:0]  lo_shamt_s;
    logic [5:0]  hi_shamt_s;
    logic [31:0] shifted_s;

    assign lo_shamt_s = {1'b0, off, 3'b000};
    assign hi_shamt_s = 6'd32 - lo_shamt_s;

    // Store side: low word gets data shifted up, high word gets the spill-over bytes.
    always_comb begin
        mask   = {4'b0000, smask} << off;
        wlane0 = wdata << lo_shamt_s;
        wlane1 = (off == 2'b00) ? 32'h0000_0000 : (wdata >> hi_shamt_s);
    end

    // Load side: realign the two-word window and extend to 32 bits.
    always_comb begin
        shifted_s = 32'({hi, lo} >> lo_shamt_s);
        case (op)
            OP_B:    rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
            OP_H:    rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
            OP_W:    rdata_ext = shifted_s;
            OP_BU:   rdata_ext = {24'h00_0000, shifted_s[7:0]};
            OP_HU:   rdata_ext = {16'h0000, shifted_s[15:0]};
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: sequences one or two word accesses per request toward byte-banked data memory.
module lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);
    import lsu_pkg::*;

    lsu_state_t  state_r;
    lsu_state_t  state_next_s;
    logic        store_r;
    logic [2:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] lo_r;
    logic [31:0] hi_r;
    logic [31:0] rdata_r;
    logic        busy_r;

    logic        legal_s;
    logic [7:0]  mask_s;
    logic [31:0] wlane0_s;
    logic [31:0] wlane1_s;
    logic [31:0] ext_s;
    logic [31:0] lo_sel_s;
    logic [31:0] hi_sel_s;
    logic [31:0] base_s;

    assign legal_s = op_legal(op, is_store);
    assign base_s  = {addr_r[31:2], 2'b00};

    // The word read this cycle feeds extraction directly so rdata is ready on entry to RESP.
    assign lo_sel_s = (state_r == ST_ACC0) ? drdata : lo_r;
    assign hi_sel_s = (state_r == ST_ACC1) ? drdata : hi_r;

    lsu_lane_align u_align (
        .wdata     (wdata_r),
        .off       (addr_r[1:0]),
        .smask     (size_mask(op_r)),
        .op        (op_r),
        .lo        (lo_sel_s),
        .hi        (hi_sel_s),
        .wlane0    (wlane0_s),
        .wlane1    (wlane1_s),
        .mask      (mask_s),
        .rdata_ext (ext_s)
    );

    // Next-state decode.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_next_s = legal_s ? ST_ACC0 : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC0: state_next_s = (mask_s[7:4] != 4'b0000) ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, request latch, read capture and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            store_r  <= 1'b0;
            op_r     <= 3'b000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            lo_r     <= 32'h0000_0000;
            hi_r     <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            if (state_r == ST_IDLE && req) begin
                store_r <= is_store;
                op_r    <= op;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
            if (state_r == ST_ACC0 && !store_r) begin
                lo_r <= drdata;
            end
            if (state_r == ST_ACC1 && !store_r) begin
                hi_r <= drdata;
            end
            // Illegal ops reach RESP straight from IDLE and report zero; stores leave rdata alone.
            if (state_next_s == ST_RESP) begin
                if (state_r == ST_IDLE) begin
                    rdata_r <= 32'h0000_0000;
                end else if (!store_r) begin
                    rdata_r <= ext_s;
                end
            end
        end
    end

    // Memory-side drive decoded from state; writes are gated off while reset is high.
    always_comb begin
        daddr  = 32'h0000_0000;
        dwdata = 32'h0000_0000;
        dwe    = 4'b0000;
        case (state_r)
            ST_ACC0: begin
                daddr  = base_s;
                dwdata = wlane0_s;
                dwe    = store_r ? mask_s[3:0] : 4'b0000;
            end
            ST_ACC1: begin
                daddr  = base_s + 32'd4;
                dwdata = wlane1_s;
                dwe    = store_r ? mask_s[7:4] : 4'b0000;
            end
            default: begin
                daddr  = 32'h0000_0000;
                dwdata = 32'h0000_0000;
                dwe    = 4'b0000;
            end
        endcase
        if (reset) begin
            dwe = 4'b0000;
        end else begin
            dwe = dwe;
        end
    end

    assign busy  = busy_r;
    assign done  = (state_r == ST_RESP);
    assign rdata = rdata_r;

endmodule
